// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller with req/ack memory handshake, stall, lane steering and timeout
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic [31:0] outMem,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        op, is_b, is_h, mis, issue, timeout;
    logic [31:0] sh, fmt, wdata;
    logic [3:0]  wstrb;
    // decode, handshake control and next state; stall/misaligned are forced low while in reset
    always_comb begin
        op         = memRead | memWrite;
        is_b       = funct3[1:0] == 2'b00;
        is_h       = funct3[1:0] == 2'b01;
        mis        = is_h ? addr[0] : (!is_b && addr[1:0] != 2'b00);
        issue      = state == IDLE && op && !mis;
        misaligned = reset && state == IDLE && op && mis;
        stall      = reset && (issue || state == WAIT);
        timeout    = state == WAIT && !mem_ack && cnt == 8'(TIMEOUT - 1);
        state_nx   = state == IDLE ? (issue ? WAIT : IDLE)
                   : state == WAIT ? ((mem_ack || timeout) ? DONE : WAIT)
                   : IDLE;
    end
    // store lane replication/strobes from live inputs, load formatting from the latched size and offset
    always_comb begin
        wdata = is_b ? {4{storeData[7:0]}} : is_h ? {2{storeData[15:0]}} : storeData;
        wstrb = memRead ? 4'b0000 : is_b ? 4'b0001 << addr[1:0] : is_h ? 4'b0011 << addr[1:0] : 4'b1111;
        sh    = mem_rdata >> {off_q, 3'b000};
        fmt   = f3_q[1:0] == 2'b00 ? {{24{sh[7] & ~f3_q[2]}}, sh[7:0]}
              : f3_q[1:0] == 2'b01 ? {{16{sh[15] & ~f3_q[2]}}, sh[15:0]}
              : mem_rdata;
    end
    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end
    // request registers, wait counter and load result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            outMem    <= '0;
            cnt       <= '0;
            bus_err   <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
        end else begin
            bus_err <= timeout;
            if (issue) begin
                mem_req   <= 1'b1;
                mem_we    <= !memRead;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wdata <= wdata;
                mem_wstrb <= wstrb;
                f3_q      <= funct3;
                off_q     <= addr[1:0];
                cnt       <= '0;
            end else if (misaligned) begin
                outMem <= '0;
            end else if (state == WAIT) begin
                if (mem_ack || timeout) begin
                    mem_req   <= 1'b0;
                    mem_wstrb <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                if (mem_ack && !mem_we) outMem <= fmt;
                else if (timeout)       outMem <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed transactions checked each cycle against a transaction-level model
module tb_mem_access_unit;
    localparam int TO = 4;
    logic        clk = 1'b0, reset = 1'b0;
    logic        memRead = 1'b0, memWrite = 1'b0, mem_ack = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, storeData = '0, mem_rdata = '0;
    logic [31:0] outMem, mem_addr, mem_wdata;
    logic        stall, misaligned, bus_err, mem_req, mem_we;
    logic [3:0]  mem_wstrb;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
        .funct3(funct3), .addr(addr), .storeData(storeData), .outMem(outMem),
        .stall(stall), .misaligned(misaligned), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic chk = 1'b0;
    logic e_stall = 0, e_mis = 0, e_berr = 0, e_req = 0, e_we = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_out = '0;
    logic [3:0]  e_wstrb = '0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_size(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [1:0] o, input logic [31:0] d);
        int s;
        logic [31:0] v;
        s = m_size(f);
        v = '0;
        for (int i = 0; i < s; i++) v[8*i +: 8] = d[8*(int'(o) + i) +: 8];
        if (s < 4 && !f[2] && v[8*s-1]) v = v | (32'hFFFFFFFF << (8*s));
        return v;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic rd, input logic [2:0] f, input logic [31:0] a);
        int s;
        if (rd) return 4'b0000;
        s = m_size(f);
        return 4'(((1 << s) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] sd);
        int s;
        logic [31:0] w;
        s = m_size(f);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % s) +: 8];
        return w;
    endfunction

    // per-cycle comparison of every DUT output against the model's expectation
    always @(negedge clk) if (chk) begin
        cmp("stall", 32'(stall), 32'(e_stall));
        cmp("misaligned", 32'(misaligned), 32'(e_mis));
        cmp("bus_err", 32'(bus_err), 32'(e_berr));
        cmp("mem_req", 32'(mem_req), 32'(e_req));
        cmp("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
        cmp("outMem", outMem, e_out);
        if (e_req) begin
            cmp("mem_addr", mem_addr, e_addr);
            cmp("mem_we", 32'(mem_we), 32'(e_we));
            if (e_we) cmp("mem_wdata", mem_wdata, e_wdata);
        end
    end

    task automatic idle(input int n);
        memRead = 0; memWrite = 0; mem_ack = 0;
        e_stall = 0; e_mis = 0; e_req = 0; e_wstrb = 0; e_berr = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // one access: ack_at = WAIT cycle index that acks, negative = never (timeout)
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rdat, input int ack_at);
        int s, n;
        logic bad, to;
        s = m_size(f);
        bad = (int'(a[1:0]) % s) != 0;
        memRead = rd; memWrite = wr; funct3 = f; addr = a; storeData = sd;
        mem_ack = 0; mem_rdata = ~rdat;
        e_stall = !bad; e_mis = bad; e_berr = 0; e_req = 0; e_wstrb = 0;
        chk = 1;
        @(posedge clk);
        #1;
        if (bad) begin
            e_out = 0; memRead = 0; memWrite = 0; e_stall = 0; e_mis = 0;
            return;
        end
        e_we = !rd; e_addr = {a[31:2], 2'b00}; e_wdata = m_wdata(f, sd);
        e_wstrb = m_wstrb(rd, f, a); e_req = 1; e_stall = 1; e_mis = 0;
        to = ack_at < 0;
        n = to ? TO : ack_at + 1;
        for (int j = 0; j < n; j++) begin
            mem_ack = (j == ack_at);
            mem_rdata = (j == ack_at) ? rdat : ~rdat;
            @(posedge clk);
            #1;
        end
        e_stall = 0; e_req = 0; e_wstrb = 0; e_berr = to;
        e_out = to ? 32'h0 : rd ? m_load(f, a[1:0], rdat) : e_out;
        mem_ack = 1; mem_rdata = 32'h0BAD0BAD;
        @(posedge clk);
        #1;
        mem_ack = 0; e_berr = 0; memRead = 0; memWrite = 0; e_stall = 0;
    endtask

    initial begin
        cmp("model_lb", m_load(3'b000, 2'd3, 32'h80112233), 32'hFFFFFF80);
        cmp("model_lbu", m_load(3'b100, 2'd3, 32'h80112233), 32'h00000080);
        cmp("model_sh_wdata", m_wdata(3'b001, 32'h0000ABCD), 32'hABCDABCD);
        cmp("model_sh_wstrb", 32'(m_wstrb(1'b0, 3'b001, 32'h202)), 32'h0000000C);
        memRead = 1;
        #3;
        cmp("rst_outMem", outMem, 32'h0);
        cmp("rst_mem_req", 32'(mem_req), 32'h0);
        cmp("rst_mem_addr", mem_addr, 32'h0);
        cmp("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        cmp("rst_bus_err", 32'(bus_err), 32'h0);
        cmp("rst_stall", 32'(stall), 32'h0);
        memRead = 0;
        @(posedge clk);
        #1;
        reset = 1;
        chk = 1;
        idle(1);
        do_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        cmp("lw_out", outMem, 32'hDEADBEEF);
        do_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
        cmp("lb_out", outMem, 32'hFFFFFF80);
        do_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 2);
        cmp("lbu_out", outMem, 32'h00000080);
        idle(1);
        do_op(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 1);
        cmp("sh_addr", mem_addr, 32'h200);
        cmp("sh_wdata", mem_wdata, 32'hABCDABCD);
        cmp("sh_we", 32'(mem_we), 32'h1);
        cmp("sh_out_kept", outMem, 32'h00000080);
        do_op(1, 0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 0);
        cmp("lh_out", outMem, 32'hFFFF8001);
        do_op(1, 0, 3'b101, 32'h102, 32'h0, 32'h80017FFF, 0);
        cmp("lhu_out", outMem, 32'h00008001);
        do_op(0, 1, 3'b000, 32'h101, 32'h123456A5, 32'h0, 0);
        cmp("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        do_op(1, 1, 3'b011, 32'h104, 32'h0000FFFF, 32'h13579BDF, 0);
        cmp("both_undef_out", outMem, 32'h13579BDF);
        idle(1);
        do_op(1, 0, 3'b010, 32'h101, 32'h0, 32'h55555555, 0);
        cmp("mis_lw_out", outMem, 32'h0);
        cmp("mis_lw_req", 32'(mem_req), 32'h0);
        idle(1);
        do_op(1, 0, 3'b010, 32'h108, 32'h0, 32'h11112222, 0);
        do_op(0, 1, 3'b001, 32'h203, 32'h0000BEEF, 32'h0, 0);
        cmp("mis_sh_out", outMem, 32'h0);
        idle(1);
        do_op(1, 0, 3'b010, 32'h10C, 32'h0, 32'h11112222, 1);
        do_op(1, 0, 3'b010, 32'h110, 32'h0, 32'h77777777, -1);
        cmp("timeout_out", outMem, 32'h0);
        idle(2);
        do_op(1, 0, 3'b010, 32'h120, 32'h0, 32'h12345678, 0);
        chk = 0;
        memRead = 1; funct3 = 3'b010; addr = 32'h124; mem_ack = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        cmp("wait_req_before_rst", 32'(mem_req), 32'h1);
        reset = 0;
        #1;
        cmp("rst_wait_req", 32'(mem_req), 32'h0);
        cmp("rst_wait_out", outMem, 32'h0);
        cmp("rst_wait_stall", 32'(stall), 32'h0);
        cmp("rst_wait_berr", 32'(bus_err), 32'h0);
        @(posedge clk);
        #1;
        reset = 1;
        e_out = 0;
        chk = 1;
        idle(1);
        do_op(0, 1, 3'b010, 32'h130, 32'hCAFEF00D, 32'h0, 0);
        cmp("sw_wdata", mem_wdata, 32'hCAFEF00D);
        cmp("sw_addr", mem_addr, 32'h130);
        cmp("sw_out", outMem, 32'h0);
        idle(2);
        chk = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
